// File: rtl/rst_ctrl.sv
// Reset controller: asynchronous assert, synchronised release, then staged
// peripheral/core release after a hold period; software reset and cause tracking.
module rst_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CORE_DELAY  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req,
    output logic       rst_periph_n,
    output logic       rst_core_n,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam int unsigned CntMax = (HOLD_CYCLES > CORE_DELAY) ? HOLD_CYCLES : CORE_DELAY;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {
        StReset,
        StHold,
        StPeriph,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   periph_q, periph_d;
    logic                   core_q, core_d;
    logic [1:0]             cause_q, cause_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;

    // Release synchroniser: cleared asynchronously, fills with ones on each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        cause_d  = cause_q;
        unique case (state_q)
            StReset: begin
                if (sync_ok) begin
                    state_d = StHold;
                    cnt_d   = CntW'(HOLD_CYCLES - 1);
                end
            end
            StHold: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d  = StPeriph;
                    periph_d = 1'b1;
                    cnt_d    = CntW'(CORE_DELAY - 1);
                end
            end
            StPeriph: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StRun;
                    core_d  = 1'b1;
                end
            end
            StRun: begin
                // Software reset bypasses the synchroniser and restarts at the hold phase.
                if (sw_rst_req) begin
                    state_d  = StHold;
                    cnt_d    = CntW'(HOLD_CYCLES - 1);
                    periph_d = 1'b0;
                    core_d   = 1'b0;
                    cause_d  = 2'b10;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StReset;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            cause_q  <= 2'b01;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            cause_q  <= cause_d;
        end
    end

    assign rst_periph_n = periph_q;
    assign rst_core_n   = core_q;
    assign rst_done     = core_q;
    assign rst_cause    = cause_q;

endmodule
